uart_frame_parser: RTL and testbench

- Consumes the 16-bit word stream from the UART receiver (single-cycle valid pulse plus data, no backpressure) and assembles framed commands.
- Frame format, in order:
  - sync word
  - header word: cmd in [15:8], len in [7:0]
  - len payload words
  - checksum word
- Payload is buffered internally and released downstream over a valid/ready stream only after the checksum passes.
- Bad frames are discarded and flagged.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_frame_parser_if.sv | 37 +++
 rtl/uart_frame_parser_frame_buffer.sv | 34 +++
 rtl/uart_frame_parser.sv | 211 +++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared types and constants for the UART frame parser.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    DRAIN   = 3'd4
  } parser_state_e;

  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hA55A;

  localparam int CMD_MSB = 15;
  localparam int CMD_LSB = 8;
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/uart_frame_parser_if.sv
// ============================================================================
// Module : uart_frame_parser_if
// Brief  : Downstream payload stream (valid/ready) plus frame cmd/len sideband.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_frame_parser_if #(
  parameter int WIDTH = 16
);
  logic             data_valid_out;
  logic             data_ready_in;
  logic [WIDTH-1:0] data_out;
  logic             data_last_out;
  logic [7:0]       cmd_out;
  logic [7:0]       len_out;

  modport master (
    output data_valid_out,
    output data_out,
    output data_last_out,
    output cmd_out,
    output len_out,
    input  data_ready_in
  );

  modport slave (
    input  data_valid_out,
    input  data_out,
    input  data_last_out,
    input  cmd_out,
    input  len_out,
    output data_ready_in
  );
endinterface

`default_nettype wire

// File: rtl/uart_frame_parser_frame_buffer.sv
// ============================================================================
// Module : uart_frame_parser_frame_buffer
// Brief  : DEPTH x WIDTH payload store, one write port, combinational read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_frame_parser_frame_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int IDXW  = 5
) (
  input  wire logic             i_clk,
  input  wire logic             i_wr_en,
  input  wire logic [IDXW-1:0]  i_wr_idx,
  input  wire logic [WIDTH-1:0] i_wr_data,
  input  wire logic [IDXW-1:0]  i_rd_idx,
  output logic      [WIDTH-1:0] o_rd_data
);

  // Payload storage carries no reset; it is always rewritten before being read.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

`default_nettype wire

// File: rtl/uart_frame_parser.sv
// ============================================================================
// Module : uart_frame_parser
// Brief  : Assembles sync/header/payload/checksum frames from a UART word
//          stream and releases verified payload over a valid/ready stream.
//          Optional inter-word timeout: define FRAME_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int          WIDTH          = 16,
  parameter int          MAX_LEN        = 32,
  parameter logic [15:0] SYNC_WORD      = DEFAULT_SYNC_WORD,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  wire logic             clk_in,
  input  wire logic             rst_n_in,
  input  wire logic             valid_in,
  input  wire logic [WIDTH-1:0] data_in,
  output logic                  frame_ok_out,
  output logic                  frame_err_out,
  output logic                  drop_out,
  output logic                  busy_out,
  uart_frame_parser_if.master   m_if
);

  localparam int         c_IDXW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [8:0] c_MAX_LEN = 9'(MAX_LEN);

  if (WIDTH < 16 || MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("uart_frame_parser: illegal parameter combination");
  end

  parser_state_e    r_state;
  logic [7:0]       r_cmd;
  logic [7:0]       r_len;
  logic [7:0]       r_cnt;
  logic [7:0]       r_rd;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_last;
  logic             r_ok;
  logic             r_err;
  logic             r_drop;

  logic [7:0]       w_len_in;
  logic             w_wr_en;
  logic [c_IDXW-1:0] w_rd_idx;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_xfer;

  assign w_len_in = data_in[LEN_MSB:LEN_LSB];
  assign w_wr_en  = (r_state == PAYLOAD) && valid_in;
  assign w_xfer   = r_valid && m_if.data_ready_in;
  // Prefetch index: word 0 when leaving CHECK, otherwise the word after r_rd.
  assign w_rd_idx = (r_state == CHECK) ? '0 : c_IDXW'(r_rd + 8'd1);

  uart_frame_parser_frame_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_LEN),
    .IDXW  (c_IDXW)
  ) u_frame_buffer (
    .i_clk     (clk_in),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_cnt[c_IDXW-1:0]),
    .i_wr_data (data_in),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

`ifdef FRAME_TIMEOUT_EN
  localparam int                c_IDLE_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYCLES - 1);
  logic [c_IDLE_W-1:0] r_idle;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= SYNC;
      r_cmd   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_sum   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      r_drop  <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      r_idle  <= '0;
`endif
    end else begin
      r_ok   <= 1'b0;
      r_err  <= 1'b0;
      r_drop <= 1'b0;

      case (r_state)
        SYNC: begin
          if (valid_in && (data_in[15:0] == SYNC_WORD)) begin
            r_state <= HEADER;
          end
        end

        HEADER: begin
          if (valid_in) begin
            r_cmd <= data_in[CMD_MSB:CMD_LSB];
            r_len <= w_len_in;
            r_sum <= data_in;
            r_cnt <= '0;
            if ({1'b0, w_len_in} > c_MAX_LEN) begin
              r_err   <= 1'b1;
              r_state <= SYNC;
            end else if (w_len_in == 8'd0) begin
              r_state <= CHECK;
            end else begin
              r_state <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (valid_in) begin
            r_sum <= r_sum + data_in;
            if (r_cnt == r_len - 8'd1) begin
              r_state <= CHECK;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end

        CHECK: begin
          if (valid_in) begin
            if (data_in == r_sum) begin
              r_ok <= 1'b1;
              if (r_len != 8'd0) begin
                r_state <= DRAIN;
                r_rd    <= '0;
                r_valid <= 1'b1;
                r_data  <= w_rd_data;
                r_last  <= (r_len == 8'd1);
              end else begin
                r_state <= SYNC;
              end
            end else begin
              r_err   <= 1'b1;
              r_state <= SYNC;
            end
          end
        end

        DRAIN: begin
          if (valid_in) begin
            r_drop <= 1'b1;
          end
          if (w_xfer) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_data  <= '0;
              r_state <= SYNC;
            end else begin
              r_rd   <= r_rd + 8'd1;
              r_data <= w_rd_data;
              r_last <= (r_rd + 8'd2 == r_len);
            end
          end
        end

        default: begin
          r_state <= SYNC;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase

`ifdef FRAME_TIMEOUT_EN
      // An incoming word always wins over an expiring timeout.
      if ((r_state == HEADER || r_state == PAYLOAD || r_state == CHECK) && !valid_in) begin
        if (r_idle == c_IDLE_LAST) begin
          r_idle  <= '0;
          r_err   <= 1'b1;
          r_state <= SYNC;
        end else begin
          r_idle <= r_idle + 1'b1;
        end
      end else begin
        r_idle <= '0;
      end
`endif
    end
  end

  assign frame_ok_out        = r_ok;
  assign frame_err_out       = r_err;
  assign drop_out            = r_drop;
  assign busy_out            = (r_state != SYNC);
  assign m_if.data_valid_out = r_valid;
  assign m_if.data_out       = r_data;
  assign m_if.data_last_out  = r_last;
  assign m_if.cmd_out        = r_cmd;
  assign m_if.len_out        = r_len;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
// ============================================================================
// Module : tb_uart_frame_parser
// Brief  : Directed self-checking bench for uart_frame_parser.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_frame_parser;

  logic        clk_in   = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [15:0] data_in  = '0;
  logic        frame_ok_out;
  logic        frame_err_out;
  logic        drop_out;
  logic        busy_out;

  int n_cmp = 0;
  int n_bad = 0;

  int n_ok   = 0;
  int n_err  = 0;
  int n_drop = 0;
  int n_excl = 0;
  logic [15:0] q_data [$];
  logic        q_last [$];
  logic [7:0]  q_cmd  [$];
  logic [7:0]  q_len  [$];

  uart_frame_parser_if #(.WIDTH(16)) s_if ();

  uart_frame_parser #(
    .WIDTH          (16),
    .MAX_LEN        (32),
    .SYNC_WORD      (16'hA55A),
`ifdef FRAME_TIMEOUT_EN
    .TIMEOUT_CYCLES (50)
`else
    .TIMEOUT_CYCLES (1_000_000)
`endif
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .frame_ok_out  (frame_ok_out),
    .frame_err_out (frame_err_out),
    .drop_out      (drop_out),
    .busy_out      (busy_out),
    .m_if          (s_if.master)
  );

  always #5 clk_in = ~clk_in;

  // Observe well after the bench drives at the falling edge.
  always @(negedge clk_in) begin
    #2;
    if (frame_ok_out)  n_ok++;
    if (frame_err_out) n_err++;
    if (drop_out)      n_drop++;
    if (int'(frame_ok_out) + int'(frame_err_out) + int'(drop_out) > 1) n_excl++;
    if (s_if.data_valid_out && s_if.data_ready_in) begin
      q_data.push_back(s_if.data_out);
      q_last.push_back(s_if.data_last_out);
      q_cmd.push_back(s_if.cmd_out);
      q_len.push_back(s_if.len_out);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    @(negedge clk_in);
    valid_in = 1'b1;
    data_in  = w;
    @(negedge clk_in);
    valid_in = 1'b0;
    data_in  = '0;
  endtask

  task automatic clear_mon();
    n_ok = 0; n_err = 0; n_drop = 0;
    q_data.delete(); q_last.delete(); q_cmd.delete(); q_len.delete();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy_out; i++) @(negedge clk_in);
    repeat (2) @(negedge clk_in);
    chk(tag, {31'd0, busy_out}, 32'd0);
  endtask

  initial begin : main
    logic [15:0] hold_bad;
    int          waited;
    s_if.data_ready_in = 1'b1;
    hold_bad = '0;

    #23;
    chk("rst_busy",  {31'd0, busy_out}, 32'd0);
    chk("rst_valid", {31'd0, s_if.data_valid_out}, 32'd0);
    chk("rst_cmd",   {24'd0, s_if.cmd_out}, 32'd0);
    chk("rst_pulses", {29'd0, frame_ok_out, frame_err_out, drop_out}, 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Stray word while idle, then a good 2-word frame.
    clear_mon();
    send_word(16'h1234);
    chk("idle_ignore", {31'd0, busy_out}, 32'd0);
    send_word(16'hA55A); send_word(16'h0302); send_word(16'h1111); send_word(16'h2222);
    send_word(16'h3635);
    chk("good_ok_lat", {31'd0, frame_ok_out}, 32'd1);
    chk("good_vld_lat", {31'd0, s_if.data_valid_out}, 32'd1);
    wait_idle("good_idle");
    chk("good_nok",   n_ok, 1);
    chk("good_nerr",  n_err, 0);
    chk("good_beats", q_data.size(), 2);
    if (q_data.size() == 2) begin
      chk("good_d0", q_data[0], 16'h1111);
      chk("good_d1", q_data[1], 16'h2222);
      chk("good_l0", q_last[0], 1'b0);
      chk("good_l1", q_last[1], 1'b1);
      chk("good_cmd", q_cmd[1], 8'h03);
      chk("good_len", q_len[1], 8'h02);
    end

    // Bad checksum.
    clear_mon();
    send_word(16'hA55A); send_word(16'h0302); send_word(16'h1111); send_word(16'h2222);
    send_word(16'h3636);
    chk("bad_err_lat", {31'd0, frame_err_out}, 32'd1);
    wait_idle("bad_idle");
    chk("bad_nerr",  n_err, 1);
    chk("bad_nok",   n_ok, 0);
    chk("bad_beats", q_data.size(), 0);

    // Backpressure with a word arriving mid-drain.
    clear_mon();
    s_if.data_ready_in = 1'b0;
    send_word(16'hA55A); send_word(16'h0503); send_word(16'h0001); send_word(16'h0002);
    send_word(16'h0003); send_word(16'h0509);
    for (int i = 0; i < 10; i++) begin
      if (s_if.data_out !== 16'h0001 || s_if.data_last_out !== 1'b0 ||
          s_if.cmd_out !== 8'h05 || s_if.len_out !== 8'h03 || s_if.data_valid_out !== 1'b1)
        hold_bad++;
      if (i == 4) begin valid_in = 1'b1; data_in = 16'hA55A; end
      if (i == 5) begin valid_in = 1'b0; data_in = '0; end
      @(negedge clk_in);
    end
    chk("bp_hold", hold_bad, 0);
    chk("bp_drop", n_drop, 1);
    chk("bp_nobeat", q_data.size(), 0);
    s_if.data_ready_in = 1'b1;
    wait_idle("bp_idle");
    chk("bp_beats", q_data.size(), 3);
    if (q_data.size() == 3) begin
      chk("bp_d0", q_data[0], 16'h0001);
      chk("bp_d1", q_data[1], 16'h0002);
      chk("bp_d2", q_data[2], 16'h0003);
      chk("bp_last", {q_last[0], q_last[1], q_last[2]}, 3'b001);
    end
    chk("bp_nok", n_ok, 1);

    // len = 0.
    clear_mon();
    send_word(16'hA55A); send_word(16'h0700); send_word(16'h0700);
    wait_idle("len0_idle");
    chk("len0_ok", n_ok, 1);
    chk("len0_beats", q_data.size(), 0);

    // len = MAX_LEN + 1 rejected at the header.
    clear_mon();
    send_word(16'hA55A); send_word(16'h0121);
    chk("long_err_lat", {31'd0, frame_err_out}, 32'd1);
    chk("long_busy", {31'd0, busy_out}, 32'd0);

    // Checksum wrap.
    clear_mon();
    send_word(16'hA55A); send_word(16'h0001); send_word(16'hFFFF); send_word(16'h0000);
    wait_idle("wrap_idle");
    chk("wrap_ok", n_ok, 1);
    chk("wrap_beats", q_data.size(), 1);
    if (q_data.size() == 1) chk("wrap_d0", {q_last[0], q_data[0]}, {1'b1, 16'hFFFF});

    // Asynchronous reset mid-payload, then a good frame.
    clear_mon();
    send_word(16'hA55A); send_word(16'h0302); send_word(16'h1111);
    #3;
    rst_n_in = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy_out}, 32'd0);
    chk("arst_len",  {24'd0, s_if.len_out}, 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    chk("arst_nopulse", n_ok + n_err, 0);
    send_word(16'hA55A); send_word(16'h0302); send_word(16'h1111); send_word(16'h2222);
    send_word(16'h3635);
    wait_idle("arst_idle");
    chk("arst_ok", n_ok, 1);
    chk("arst_beats", q_data.size(), 2);

`ifdef FRAME_TIMEOUT_EN
    clear_mon();
    send_word(16'hA55A); send_word(16'h0101);
    waited = 0;
    while (!frame_err_out && waited < 200) begin
      @(negedge clk_in);
      waited++;
    end
    chk("to_cycles", waited, 50);
    wait_idle("to_idle");
    clear_mon();
    send_word(16'hA55A); send_word(16'h0101); send_word(16'h0042); send_word(16'h0143);
    wait_idle("to_after_idle");
    chk("to_after_ok", n_ok, 1);
`else
    waited = 0;
`endif

    chk("exclusive", n_excl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
